// File: rtl/sme_rng_buf.sv
// Randomness buffer between the SME random source and the masked datapath.
// Requests batches one at a time, queues them, and zeroes each slot as it is consumed.
module sme_rng_buf #(
  parameter int XLEN    = 32,
  parameter int SMAX    = 3,
  parameter int DEPTH   = 2,
  parameter int RNG_LAT = 1,
  localparam int RMAX   = SMAX + SMAX * (SMAX - 1) / 2,
  localparam int RW     = RMAX * XLEN - 1,
  localparam int FW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  output logic          g_clk_req,
  input  logic          flush,
  output logic          rng_update,
  input  logic [RW:0]   rng_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW:0]   out_rng,
  output logic [FW-1:0] fill
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [FW-1:0]   fill_r;
  logic [RW:0]     mem_r [DEPTH];

  logic            capture_s;
  logic            pop_s;
  logic            not_full_s;

  assign not_full_s = (fill_r < FW'(DEPTH));
  // flush suppresses both capture and pop so in-flight randomness is discarded
  assign capture_s  = (state_r == WAIT) && (cnt_r == 4'd0) && !flush;
  assign pop_s      = (fill_r != '0) && out_ready && !flush;

  // Request FSM, batch storage, pointers and occupancy
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[PW'(i)] <= '0;
      end
    end else if (flush) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[PW'(i)] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (not_full_s) begin
            state_r <= UPD;
          end else begin
            state_r <= IDLE;
          end
        end
        UPD: begin
          state_r <= WAIT;
          cnt_r   <= 4'(RNG_LAT - 1);
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase

      // capture never targets the head slot while a pop is possible, so both writes are disjoint
      if (capture_s) begin
        mem_r[wr_ptr_r] <= rng_in;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        mem_r[rd_ptr_r] <= '0;
        rd_ptr_r        <= rd_ptr_r + PW'(1);
      end

      case ({capture_s, pop_s})
        2'b10:   fill_r <= fill_r + FW'(1);
        2'b01:   fill_r <= fill_r - FW'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  assign rng_update = (state_r == UPD) && !flush;
  assign out_valid  = (fill_r != '0);
  assign out_rng    = out_valid ? mem_r[rd_ptr_r] : '0;
  assign fill       = fill_r;
  assign g_clk_req  = not_full_s || (state_r != IDLE);

endmodule

// File: tb/tb_sme_rng_buf.sv
// Self-checking bench for sme_rng_buf: directed scenarios plus randomized traffic
// compared against a queue-based model of batch requests, captures and pops.
module tb_sme_rng_buf;

  localparam int XLEN  = 32;
  localparam int SMAX  = 3;
  localparam int RMAX  = SMAX + SMAX * (SMAX - 1) / 2;
  localparam int BW    = RMAX * XLEN;
  localparam int DEPTH = 2;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int LAT   = 1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, out_ready, rng_update, out_valid, clk_req;
  logic [BW-1:0] rng_in, out_rng;
  logic [FW-1:0] fill;

  logic          rst4_n, flush4, ready4, upd4, valid4, req4;
  logic [BW-1:0] rng_in4, rng4;
  logic [FW-1:0] fill4;

  sme_rng_buf #(.XLEN(XLEN), .SMAX(SMAX), .DEPTH(DEPTH), .RNG_LAT(LAT)) dut (
    .g_clk(clk), .g_resetn(rst_n), .g_clk_req(clk_req), .flush(flush),
    .rng_update(rng_update), .rng_in(rng_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_rng(out_rng), .fill(fill)
  );

  sme_rng_buf #(.XLEN(XLEN), .SMAX(SMAX), .DEPTH(DEPTH), .RNG_LAT(4)) dut4 (
    .g_clk(clk), .g_resetn(rst4_n), .g_clk_req(req4), .flush(flush4),
    .rng_update(upd4), .rng_in(rng_in4), .out_valid(valid4),
    .out_ready(ready4), .out_rng(rng4), .fill(fill4)
  );

  int comp_cnt = 0;
  int fail_cnt = 0;

  // Reference model: queue of buffered batches plus the cycle numbers of the next
  // request decision, update pulse and capture.
  logic [BW-1:0] mq[$];
  int            mcyc, m_dec, m_upd, m_cap;
  logic          exp_upd, exp_valid, exp_req;
  logic [BW-1:0] exp_rng;
  logic [FW-1:0] exp_fill;

  function automatic logic [BW-1:0] rand_batch();
    logic [BW-1:0] b;
    for (int r = 0; r < RMAX; r++) b[r*XLEN +: XLEN] = $urandom();
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    mcyc  = 0;
    m_dec = 0;
    m_upd = -1;
    m_cap = -1;
  endtask

  task automatic settle();
    #1;
    exp_upd   = (mcyc == m_upd) && !flush;
    exp_fill  = FW'(mq.size());
    exp_valid = (mq.size() != 0);
    exp_rng   = exp_valid ? mq[0] : '0;
    exp_req   = (mq.size() < DEPTH) || (mcyc != m_dec);
  endtask

  task automatic advance();
    int old;
    old = mq.size();
    if (flush) begin
      mq.delete();
      m_dec = mcyc + 1;
      m_upd = -1;
      m_cap = -1;
    end else begin
      if (old != 0 && out_ready) mq.delete(0);
      if (mcyc == m_cap) mq.push_back(rng_in);
      if (mcyc == m_dec) begin
        if (old < DEPTH) begin
          m_upd = mcyc + 1;
          m_cap = mcyc + 1 + LAT;
          m_dec = m_cap + 1;
        end else begin
          m_dec = mcyc + 1;
        end
      end
    end
    mcyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; rng_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [BW-1:0] pat;
    pat = {RMAX{32'hA5A5A5A5}};
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; rng_in = pat;
    #1;
    comp_cnt++; if (rng_update !== 1'b0) begin fail_cnt++; $display("FAIL rst_upd got %b want 0", rng_update); end
    comp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid got %b want 0", out_valid); end
    comp_cnt++; if (out_rng !== '0) begin fail_cnt++; $display("FAIL rst_rng got %h want 0", out_rng); end
    comp_cnt++; if (fill !== 2'd0) begin fail_cnt++; $display("FAIL rst_fill got %0d want 0", fill); end
    comp_cnt++; if (clk_req !== 1'b1) begin fail_cnt++; $display("FAIL rst_req got %b want 1", clk_req); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      settle();
      comp_cnt++;
      if (rng_update !== (c == 1)) begin fail_cnt++; $display("FAIL first_upd cyc %0d got %b want %b", c, rng_update, (c == 1)); end
      if (c == 3) begin
        comp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL first_valid got %b want 1", out_valid); end
        comp_cnt++; if (out_rng !== pat) begin fail_cnt++; $display("FAIL first_rng got %h want %h", out_rng, pat); end
        comp_cnt++; if (fill !== 2'd1) begin fail_cnt++; $display("FAIL first_fill got %0d want 1", fill); end
      end
      advance();
    end
  endtask

  task automatic test_fill_full();
    int pulses;
    do_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      rng_in = BW'(pulses);
      settle();
      if (rng_update === 1'b1) pulses++;
      advance();
    end
    settle();
    comp_cnt++; if (pulses != 2) begin fail_cnt++; $display("FAIL full_pulses got %0d want 2", pulses); end
    comp_cnt++; if (fill !== 2'd2) begin fail_cnt++; $display("FAIL full_fill got %0d want 2", fill); end
    advance();
    for (int c = 0; c < 20; c++) begin
      settle();
      comp_cnt++; if (clk_req !== 1'b0) begin fail_cnt++; $display("FAIL full_req cyc %0d got %b want 0", c, clk_req); end
      comp_cnt++; if (rng_update !== 1'b0) begin fail_cnt++; $display("FAIL full_upd cyc %0d got %b want 0", c, rng_update); end
      advance();
    end
  endtask

  task automatic test_pop();
    out_ready = 1'b1;
    settle();
    comp_cnt++; if (out_rng !== BW'(1)) begin fail_cnt++; $display("FAIL pop_b1 got %h want 1", out_rng); end
    advance();
    settle();
    comp_cnt++; if (out_rng !== BW'(2)) begin fail_cnt++; $display("FAIL pop_b2 got %h want 2", out_rng); end
    comp_cnt++; if (fill !== 2'd1) begin fail_cnt++; $display("FAIL pop_fill1 got %0d want 1", fill); end
    comp_cnt++; if (dut.mem_r[1'b0] !== '0) begin fail_cnt++; $display("FAIL pop_slot0 got %h want 0", dut.mem_r[1'b0]); end
    advance();
    out_ready = 1'b0;
    settle();
    comp_cnt++; if (out_rng !== '0) begin fail_cnt++; $display("FAIL pop_empty got %h want 0", out_rng); end
    comp_cnt++; if (fill !== 2'd0) begin fail_cnt++; $display("FAIL pop_fill0 got %0d want 0", fill); end
    comp_cnt++; if (rng_update !== 1'b1) begin fail_cnt++; $display("FAIL pop_refill got %b want 1", rng_update); end
    comp_cnt++; if (dut.mem_r[1'b1] !== '0) begin fail_cnt++; $display("FAIL pop_slot1 got %h want 0", dut.mem_r[1'b1]); end
    advance();
  endtask

  task automatic test_stream();
    int popped, last_pop;
    do_reset();
    out_ready = 1'b1;
    popped = 0;
    last_pop = -1;
    for (int c = 0; c < 120 && popped < 16; c++) begin
      rng_in = rand_batch();
      settle();
      comp_cnt++; if (out_valid !== exp_valid) begin fail_cnt++; $display("FAIL stream_valid cyc %0d got %b want %b", c, out_valid, exp_valid); end
      if (exp_valid) begin
        comp_cnt++; if (out_rng !== exp_rng) begin fail_cnt++; $display("FAIL stream_data %0d got %h want %h", popped, out_rng, exp_rng); end
        if (last_pop >= 0) begin
          comp_cnt++; if (c - last_pop != 3) begin fail_cnt++; $display("FAIL stream_cadence got %0d want 3", c - last_pop); end
        end
        popped++;
        last_pop = c;
      end
      advance();
    end
    comp_cnt++; if (popped != 16) begin fail_cnt++; $display("FAIL stream_count got %0d want 16", popped); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_capture();
    logic [BW-1:0] marker, fresh;
    marker = {RMAX{32'hDEADBEEF}};
    fresh  = {RMAX{32'h600DF00D}};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      rng_in = rand_batch();
      settle();
      advance();
    end
    rng_in = marker;
    flush  = 1'b1;
    settle();
    comp_cnt++; if (fill !== 2'd1) begin fail_cnt++; $display("FAIL fl_pre_fill got %0d want 1", fill); end
    comp_cnt++; if (rng_update !== 1'b0) begin fail_cnt++; $display("FAIL fl_upd got %b want 0", rng_update); end
    advance();
    flush  = 1'b0;
    rng_in = fresh;
    settle();
    comp_cnt++; if (fill !== 2'd0) begin fail_cnt++; $display("FAIL fl_fill got %0d want 0", fill); end
    comp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL fl_valid got %b want 0", out_valid); end
    comp_cnt++; if (out_rng !== '0) begin fail_cnt++; $display("FAIL fl_rng got %h want 0", out_rng); end
    advance();
    settle();
    comp_cnt++; if (rng_update !== 1'b1) begin fail_cnt++; $display("FAIL fl_reupd got %b want 1", rng_update); end
    advance();
    settle();
    advance();
    settle();
    comp_cnt++; if (out_rng !== fresh) begin fail_cnt++; $display("FAIL fl_fresh got %h want %h", out_rng, fresh); end
    comp_cnt++; if (fill !== 2'd1) begin fail_cnt++; $display("FAIL fl_fill1 got %0d want 1", fill); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      rng_in    = rand_batch();
      settle();
      comp_cnt++; if (rng_update !== exp_upd) begin fail_cnt++; $display("FAIL rnd_upd cyc %0d got %b want %b", c, rng_update, exp_upd); end
      comp_cnt++; if (out_valid !== exp_valid) begin fail_cnt++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, exp_valid); end
      comp_cnt++; if (out_rng !== exp_rng) begin fail_cnt++; $display("FAIL rnd_rng cyc %0d got %h want %h", c, out_rng, exp_rng); end
      comp_cnt++; if (fill !== exp_fill) begin fail_cnt++; $display("FAIL rnd_fill cyc %0d got %0d want %0d", c, fill, exp_fill); end
      comp_cnt++; if (clk_req !== exp_req) begin fail_cnt++; $display("FAIL rnd_req cyc %0d got %b want %b", c, clk_req, exp_req); end
      advance();
    end
    flush = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    rng_in4 = {RMAX{32'h13579BDF}};
    @(negedge clk);
    rst4_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      comp_cnt++; if (upd4 !== (c == 1)) begin fail_cnt++; $display("FAIL l4_upd cyc %0d got %b want %b", c, upd4, (c == 1)); end
      @(negedge clk);
    end
    #2;
    rst4_n = 1'b0;
    #1;
    comp_cnt++; if (upd4 !== 1'b0) begin fail_cnt++; $display("FAIL l4_rst_upd got %b want 0", upd4); end
    comp_cnt++; if (valid4 !== 1'b0) begin fail_cnt++; $display("FAIL l4_rst_valid got %b want 0", valid4); end
    comp_cnt++; if (rng4 !== '0) begin fail_cnt++; $display("FAIL l4_rst_rng got %h want 0", rng4); end
    comp_cnt++; if (fill4 !== 2'd0) begin fail_cnt++; $display("FAIL l4_rst_fill got %0d want 0", fill4); end
    comp_cnt++; if (req4 !== 1'b1) begin fail_cnt++; $display("FAIL l4_rst_req got %b want 1", req4); end
    @(negedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      comp_cnt++; if (fill4 !== ((c >= 6) ? 2'd1 : 2'd0)) begin fail_cnt++; $display("FAIL l4_fill cyc %0d got %0d want %0d", c, fill4, (c >= 6)); end
      comp_cnt++; if (upd4 !== (c == 1)) begin fail_cnt++; $display("FAIL l4_reupd cyc %0d got %b want %b", c, upd4, (c == 1)); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; rng_in = '0;
    rst4_n = 1'b0; flush4 = 1'b0; ready4 = 1'b0; rng_in4 = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill_full();
    test_pop();
    test_stream();
    test_flush_capture();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sme_rng_buf.md
# sme_rng_buf

Randomness buffer sitting directly downstream of the SME random number source. It requests fresh guard-share batches from the source by pulsing its update input, captures each batch of RMAX XLEN-bit words into a small FIFO, and hands whole batches to the SME masked datapath over a valid/ready port. Each captured batch is delivered at most once and cleared on consumption, so masking randomness is never reused.

## Interface

- XLEN, 32, width of one random word.
- SMAX, 3, number of shares; RMAX = SMAX+SMAX*(SMAX-1)/2 (6 at defaults) words per batch; RW = RMAX*XLEN-1.
- DEPTH, 2, FIFO depth in batches; power of two, at least 2.
- RNG_LAT, 1, cycles after an update pulse before rng_in holds the new batch; 1..15.
- g_clk  input  1  clock; all state changes on rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- g_clk_req  output  1  clock request: high when fill < DEPTH or state != IDLE.
- flush  input  1  synchronous discard of all buffered and in-flight randomness.
- rng_update  output  1  one-cycle update pulse to the random source.
- rng_in  input  RW+1  current batch from the random source.
- out_valid  output  1  a batch is available.
- out_ready  input  1  consumer accepts the batch this cycle.
- out_rng  output  RW+1  head batch; all zeros when out_valid is 0.
- fill  output  $clog2(DEPTH+1)  number of buffered batches.

## Operation

- FSM states: IDLE, UPD, WAIT.
- IDLE: if fill < DEPTH (registered value) go to UPD, else stay.
- UPD: rng_update = 1 for exactly this cycle; next state WAIT, wait counter loaded with RNG_LAT-1.
- WAIT: counter decrements each cycle; in the cycle it reads 0, rng_in is written to mem[wr_ptr], wr_ptr increments, and the FSM returns to IDLE.
- Only one request is ever in flight. Capture therefore never occurs with the FIFO full.
- Pop: when out_valid && out_ready, mem[rd_ptr] is zeroed and rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap naturally. fill is tracked explicitly.
- Simultaneous capture and pop: fill is unchanged and both pointers advance.
- out_valid = (fill != 0). out_rng = out_valid ? mem[rd_ptr] : 0.
- flush, which has priority over capture, pop and FSM transitions:
  - fill = 0, pointers = 0, all entries zeroed, FSM forced to IDLE, counter cleared.
  - rng_update is not asserted in the flush cycle.
  - A batch being captured in that cycle is dropped.
- Reset, asynchronous and usable mid-operation: every register is cleared immediately.
  - FSM = IDLE, fill = 0, pointers = 0, memory = 0.
  - rng_update = 0, out_valid = 0, out_rng = 0, g_clk_req = 1 (because fill < DEPTH).
- rng_in is sampled only in the capture cycle and is otherwise ignored.

## Timing

- Let cycle 0 be the first cycle after g_resetn rises; the FSM is in IDLE.
- Cycle 1: UPD, rng_update = 1.
- Cycles 2..RNG_LAT+1: WAIT. Capture happens at the end of cycle RNG_LAT+1.
- Cycle RNG_LAT+2: fill = 1, out_valid = 1.
- Refill cadence: one batch every RNG_LAT+2 cycles (IDLE, UPD, and RNG_LAT WAIT cycles).
- Pop latency: fill and out_valid update in the cycle after the handshake. out_rng shows the next head combinationally from the registered rd_ptr.
- Steady full state: the FSM stays in IDLE, g_clk_req = 0, rng_update = 0.
- After a flush in cycle t: out_valid = 0 in cycle t+1, UPD in cycle t+2, rng_update = 1 in cycle t+2.

## Test plan

- Reset release with RNG_LAT=1 and rng_in = 0xA5A5…: rng_update high only in cycle 1, out_valid rises in cycle 3, out_rng = 0xA5A5…, fill = 1.
- Fill to full with out_ready = 0 and distinct rng_in per update (counter pattern 1, 2):
  - fill reaches 2 and exactly 2 update pulses occur.
  - g_clk_req then drops to 0, and rng_update stays 0 for 20 cycles.
- Pop both batches back to back:
  - out_rng reads batch 1, then batch 2, then 0.
  - Each popped slot reads 0 internally.
  - Refill resumes with an update pulse in the cycle after fill drops below DEPTH.
- Continuous out_ready = 1 for 16 batches: FIFO order is preserved across pointer wrap, no batch is delivered twice, and the cadence is one batch per 3 cycles.
- Flush in the capture cycle with fill = 1:
  - fill = 0, out_valid = 0 and out_rng = 0 in the next cycle.
  - The in-flight batch never appears.
  - A new update pulse occurs 2 cycles after the flush.
- Assert g_resetn low mid-WAIT with RNG_LAT=4: all outputs return to reset values without a clock edge, and no capture occurs after reset release until a fresh UPD.
